// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, parity mode codes and a frame-length helper
// used by the transmitter, the receiver and their benches.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Whole frame in clk cycles: start + data + optional parity + stop bits.
  function automatic int frame_clks(input int data_bits, input int clks_per_bit,
                                    input int parity_mode, input int stop_bits);
    return clks_per_bit * (1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of
// each bit with bit_end. clr restarts the count so a new bit period begins next cycle.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic prst_n,
  input  logic en,
  input  logic clr,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge prst_n) begin
    if (!prst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

  // Not gated by clr: the transmitter needs bit_end to open tx_ready in the
  // same cycle a back-to-back accept is taken.
  assign bit_end = en && (count == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready word input, start + LSB-first data +
// optional parity + 1..2 stop bits on a registered, idle-high serial line.
//
// Handshake: a word is accepted on a rising clk edge where tx_valid && tx_ready;
// tx_ready depends only on registered state, tx_valid may drop at any time, and
// tx_data is looked at only on the accepting edge.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 prst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 serial_out,
  output logic                 busy,
  output logic                 frame_done,
  output logic [2:0]           dbg_state
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic LAST_STOP = (STOP_BITS == 2);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $fatal(1, "uart_tx_param: DATA_BITS must be in 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $fatal(1, "uart_tx_param: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity_mode
    $fatal(1, "uart_tx_param: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $fatal(1, "uart_tx_param: STOP_BITS must be 1 or 2");
  end

  uart_state_e          state, state_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic [IDX_W-1:0]     bit_idx, bit_idx_d;
  logic                 stop_idx, stop_idx_d;
  logic                 parity_bit, parity_d;
  logic                 serial_d;
  logic                 armed;
  logic                 bit_end;
  logic                 last_stop;
  logic                 accept;

  // armed keeps tx_ready low through reset and opens it on the first edge after release.
  assign last_stop  = (state == ST_STOP) && (stop_idx == LAST_STOP) && bit_end;
  assign tx_ready   = armed && ((state == ST_IDLE) || last_stop);
  assign accept     = tx_valid && tx_ready;
  assign busy       = (state != ST_IDLE);
  assign frame_done = last_stop;
  assign dbg_state  = state;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk     (clk),
    .prst_n  (prst_n),
    .en      (busy),
    .clr     (accept),
    .bit_end (bit_end)
  );

  // serial_d is the line level for whichever bit begins on the next edge.
  always_comb begin
    state_d    = state;
    shreg_d    = shreg;
    bit_idx_d  = bit_idx;
    stop_idx_d = stop_idx;
    parity_d   = parity_bit;
    serial_d   = serial_out;

    if (accept) begin
      state_d    = ST_START;
      shreg_d    = tx_data;
      parity_d   = (PARITY_MODE == PARITY_ODD) ? ~^tx_data : ^tx_data;
      bit_idx_d  = '0;
      stop_idx_d = 1'b0;
      serial_d   = 1'b0;
    end else if (bit_end) begin
      case (state)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_START: begin
          state_d  = ST_DATA;
          serial_d = shreg[0];
        end
        ST_DATA: begin
          if (bit_idx == LAST_IDX) begin
            if (PARITY_MODE != PARITY_NONE) begin
              state_d  = ST_PARITY;
              serial_d = parity_bit;
            end else begin
              state_d  = ST_STOP;
              serial_d = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx + IDX_W'(1);
            shreg_d   = shreg >> 1;
            serial_d  = shreg[1];
          end
        end
        ST_PARITY: begin
          state_d    = ST_STOP;
          stop_idx_d = 1'b0;
          serial_d   = 1'b1;
        end
        ST_STOP: begin
          serial_d = 1'b1;
          if (stop_idx == LAST_STOP) begin
            state_d    = ST_IDLE;
            stop_idx_d = 1'b0;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          serial_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge prst_n) begin
    if (!prst_n) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      parity_bit <= 1'b0;
      serial_out <= 1'b1;
      armed      <= 1'b0;
    end else begin
      state      <= state_d;
      shreg      <= shreg_d;
      bit_idx    <= bit_idx_d;
      stop_idx   <= stop_idx_d;
      parity_bit <= parity_d;
      serial_out <= serial_d;
      armed      <= 1'b1;
    end
  end

endmodule
